ad9970_sync_tx: RTL
===================

AD9970_SYNC_TX -- requirements
Module: ad9970_sync_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 14: pixel input width; fixed 14, output word 16 bits.
REQ-002 Parameter SYNC_LOC_DEF, default 13'd252: reset value of the sync start location.
REQ-003 Parameter SYNC_WORD_DEF, default 16'h8421: reset value of all four sync words.
REQ-004 Parameter HBLK_TOG1_DEF, default 0, and HBLK_TOG2_DEF, default 265: reset values of the blanking edges.
REQ-005 clk  input  1  pixel clock; all logic on rising edge.
REQ-006 reset_n  input  1  synchronous, active-low reset.
REQ-007 iv_pix_data  input  14  pixel sample, one per clk.
REQ-008 i_hd  input  1  line sync, active-high level.
REQ-009 i_vd  input  1  frame sync, active-high level.
REQ-010 iv_sync_start_loc  input  13  h_cnt value of the first sync word.
REQ-011 iv_sync_word0..iv_sync_word3  input  16 each  sync words, emitted in order 0..3.
REQ-012 i_align_right  input  1  1 = right-align pixel in the word, 0 = left-align.
REQ-013 iv_hblk_tog1, iv_hblk_tog2  input  13 each  blanking start and end (end exclusive).
REQ-014 ov_lane0  output  8  word[15:8] for the lane-0 serializer.
REQ-015 ov_lane1  output  8  word[7:0] for the lane-1 serializer.
REQ-016 o_word_valid  output  1  lanes carry a defined word this cycle.
REQ-017 o_sync  output  1  the current word is a sync word.
REQ-018 o_data_en  output  1  the current word is an active pixel.

Function
REQ-019 FSM states: IDLE and ACTIVE; IDLE -> ACTIVE on the first i_vd rising edge (registered-edge detect); ACTIVE -> IDLE only on reset.
REQ-020 In IDLE: lanes = 0; o_word_valid, o_sync and o_data_en = 0.
REQ-021 Shadow registers latch all config inputs on every i_vd rising edge and hold them for the frame.
REQ-022 Changing a config input mid-frame has no effect until the next i_vd rising edge.
REQ-023 h_cnt is 13 bits; an i_hd rising edge loads 0; otherwise h_cnt increments and saturates at 8191.
REQ-024 Sync trigger: h_cnt == shadow sync_start_loc starts a 2-bit sync index at 0.
REQ-025 The sync index emits sync_word0..3 on four consecutive cycles, independent of h_cnt saturation.
REQ-026 An i_hd rising edge during a sync sequence aborts it; the remaining sync words are not emitted.
REQ-027 Word select priority: sync word > blank word 16'h0000 when tog1 <= h_cnt < tog2 > pixel word.
REQ-028 Pixel word = {2'b00, pix} when align_right = 1; {pix, 2'b00} when align_right = 0.
REQ-029 If tog1 >= tog2, no blanking region exists; all non-sync cycles are pixel words.
REQ-030 o_sync = 1 only on sync words; o_data_en = 1 only on pixel words; o_word_valid = 1 in every ACTIVE cycle.
REQ-031 Latency: iv_pix_data sampled at edge N appears on the lanes at edge N+2 (input register, output register).
REQ-032 h_cnt, sync and blank decisions are delayed to match the pixel pipeline exactly.
REQ-033 i_vd and i_hd rising on the same edge: shadow update and h_cnt clear both occur.
REQ-034 That line uses the new config.

Reset
REQ-035 With reset_n = 0 at a clk edge:
- state = IDLE; h_cnt = 0; sync index idle; pipeline registers = 0.
- all outputs = 0.
- shadows = parameter defaults; align_right shadow = 1.
REQ-036 Reset asserted mid-line or mid-sync takes effect at the next clk edge; on release, output stays idle until a new i_vd rising edge.

Verification
REQ-037 Bench scenarios:
- Reset, then i_vd pulse, i_hd pulse, defaults -> at h_cnt 252..255 the lanes read 84/21 four times with o_sync = 1; h_cnt 0..264 otherwise 00/00 with o_data_en = 0.
- Pixel 14'h3ABC, align_right = 1, h_cnt 300 -> lanes 3A/BC two cycles later; align_right = 0 (after the next vd) -> lanes EA/F0.
- Change sync_start_loc to 100 mid-frame -> sync remains at 252 in this frame and moves to 100 after the next i_vd.
- i_hd pulse at h_cnt 253 -> only word0 and word1 emitted, h_cnt restarts at 0, and the next sync occurs at 252.
- sync_start_loc = 8190 on a line with no further hd -> all four sync words emitted at counts 8190, 8191, then saturated 8191 twice.
- reset_n low during the sync sequence -> all outputs 0 the next cycle, and they remain 0 after release until an i_vd edge.

Source files
------------

// File: rtl/ad9970_sync_tx.sv
// AD9970 transmit word builder: frames 14-bit pixels into 16-bit words split over
// two 8-bit serializer lanes, inserting a 4-word sync code and a blanking window per line.
module ad9970_sync_tx #(
  parameter int          DATA_WIDTH    = 14,
  parameter logic [12:0] SYNC_LOC_DEF  = 13'd252,
  parameter logic [15:0] SYNC_WORD_DEF = 16'h8421,
  parameter logic [12:0] HBLK_TOG1_DEF = 13'd0,
  parameter logic [12:0] HBLK_TOG2_DEF = 13'd265
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] iv_pix_data,
  input  logic                  i_hd,
  input  logic                  i_vd,
  input  logic [12:0]           iv_sync_start_loc,
  input  logic [15:0]           iv_sync_word0,
  input  logic [15:0]           iv_sync_word1,
  input  logic [15:0]           iv_sync_word2,
  input  logic [15:0]           iv_sync_word3,
  input  logic                  i_align_right,
  input  logic [12:0]           iv_hblk_tog1,
  input  logic [12:0]           iv_hblk_tog2,
  output logic [7:0]            ov_lane0,
  output logic [7:0]            ov_lane1,
  output logic                  o_word_valid,
  output logic                  o_sync,
  output logic                  o_data_en
);

  localparam int PAD = 16 - DATA_WIDTH;

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

  state_t                r_state, w_state_next;
  logic                  r_hd_d, r_vd_d;
  logic                  w_hd_rise, w_vd_rise;
  logic [DATA_WIDTH-1:0] r_pix;
  logic [12:0]           r_hcnt;
  logic                  r_sync_act;
  logic [1:0]            r_sync_idx;
  logic [12:0]           r_sh_loc, r_sh_tog1, r_sh_tog2;
  logic [15:0]           r_sh_word [4];
  logic [15:0]           w_cfg_word [4];
  logic                  r_sh_align;
  logic                  w_sync_trig, w_sync_sel, w_blank;
  logic [1:0]            w_sync_idx;
  logic [15:0]           w_pix_word, w_word;
  logic [15:0]           r_word;
  logic                  r_valid, r_sync, r_den;

  assign w_hd_rise = i_hd & ~r_hd_d;
  assign w_vd_rise = i_vd & ~r_vd_d;

  assign w_cfg_word[0] = iv_sync_word0;
  assign w_cfg_word[1] = iv_sync_word1;
  assign w_cfg_word[2] = iv_sync_word2;
  assign w_cfg_word[3] = iv_sync_word3;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_hd_d  <= 1'b0;
      r_vd_d  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_hd_d  <= i_hd;
      r_vd_d  <= i_vd;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (r_state == ST_IDLE && w_vd_rise) w_state_next = ST_ACTIVE;
  end

  // Config is frame-stable: only a vd rising edge refreshes the shadows.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sh_loc   <= SYNC_LOC_DEF;
      r_sh_tog1  <= HBLK_TOG1_DEF;
      r_sh_tog2  <= HBLK_TOG2_DEF;
      r_sh_align <= 1'b1;
      for (int i = 0; i < 4; i++) r_sh_word[i] <= SYNC_WORD_DEF;
    end else if (w_vd_rise) begin
      r_sh_loc   <= iv_sync_start_loc;
      r_sh_tog1  <= iv_hblk_tog1;
      r_sh_tog2  <= iv_hblk_tog2;
      r_sh_align <= i_align_right;
      for (int i = 0; i < 4; i++) r_sh_word[i] <= w_cfg_word[i];
    end
  end

  // Input stage: pixel and its line position travel together.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pix  <= '0;
      r_hcnt <= '0;
    end else begin
      r_pix <= iv_pix_data;
      if (w_hd_rise)              r_hcnt <= '0;
      else if (r_hcnt != 13'h1FFF) r_hcnt <= r_hcnt + 13'd1;
    end
  end

  // Words 1..3 of the sync code follow the trigger regardless of h_cnt.
  always_ff @(posedge clk) begin
    if (!reset_n || w_hd_rise) begin
      r_sync_act <= 1'b0;
      r_sync_idx <= 2'd0;
    end else if (w_sync_trig) begin
      r_sync_act <= 1'b1;
      r_sync_idx <= 2'd1;
    end else if (r_sync_act) begin
      if (r_sync_idx == 2'd3) r_sync_act <= 1'b0;
      r_sync_idx <= r_sync_idx + 2'd1;
    end
  end

  assign w_sync_trig = (r_hcnt == r_sh_loc);
  assign w_sync_sel  = w_sync_trig | r_sync_act;
  assign w_sync_idx  = w_sync_trig ? 2'd0 : r_sync_idx;
  assign w_blank     = (r_hcnt >= r_sh_tog1) && (r_hcnt < r_sh_tog2);
  assign w_pix_word  = r_sh_align ? {{PAD{1'b0}}, r_pix} : {r_pix, {PAD{1'b0}}};

  always_comb begin
    w_word = w_pix_word;
    if (w_sync_sel)   w_word = r_sh_word[w_sync_idx];
    else if (w_blank) w_word = 16'h0000;
  end

  always_ff @(posedge clk) begin
    if (!reset_n || r_state == ST_IDLE) begin
      r_word  <= '0;
      r_valid <= 1'b0;
      r_sync  <= 1'b0;
      r_den   <= 1'b0;
    end else begin
      r_word  <= w_word;
      r_valid <= 1'b1;
      r_sync  <= w_sync_sel;
      r_den   <= ~w_sync_sel & ~w_blank;
    end
  end

  assign ov_lane0     = r_word[15:8];
  assign ov_lane1     = r_word[7:0];
  assign o_word_valid = r_valid;
  assign o_sync       = r_sync;
  assign o_data_en    = r_den;

endmodule
